fifo_rd_stream: RTL and testbench

Single-clock read-side adapter that connects to the read port of the team's asynchronous FIFO and turns it into a valid/ready stream.
- It issues `fifo_rd_en` only when the FIFO is not empty and buffer space is guaranteed.
- It absorbs the FIFO's one-cycle registered read latency.
- It sustains one word per cycle through a 2-entry output buffer.
- It sits in the read clock domain, between the FIFO and any downstream consumer.

---
 rtl/fifo_rd_stream.sv | 157 +++++++++++++++
 tb/tb_fifo_rd_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter from the async FIFO read port to a
// valid/ready stream. Absorbs the FIFO's one-cycle read latency and keeps
// up to two words in a small output buffer so one word per cycle is sustained.
// Optional performance counters are built when FIFO_RD_STREAM_PERF_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | buffer holds no word, m_valid low
// S_ONE   | head slot holds the next stream word
// S_TWO   | head and tail slots both hold words (full)
//
// The inflight flag runs alongside the state: a read was granted at the last
// edge, so fifo_data now carries that word and it is captured at the next edge.

module fifo_rd_stream #(
  parameter int data_width = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_reset_n,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data
`ifdef FIFO_RD_STREAM_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [15:0]           perf_words,
  output logic [15:0]           perf_stalls
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_state_t;

  occ_state_t            state;
  occ_state_t            state_nxt;
  logic                  inflight;
  logic                  inflight_nxt;
  logic [data_width-1:0] head;
  logic [data_width-1:0] head_nxt;
  logic [data_width-1:0] tail;
  logic [data_width-1:0] tail_nxt;
  logic [1:0]            occ;
  logic [2:0]            level;
  logic                  pop;

  // Numeric occupancy from the state, for the read-issue space check.
  always_comb begin
    occ = 2'd0;
    case (state)
      S_EMPTY: occ = 2'd0;
      S_ONE:   occ = 2'd1;
      S_TWO:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  assign level   = {1'b0, occ} + {2'b00, inflight};
  assign m_valid = (state != S_EMPTY);
  assign m_data  = head;
  assign pop     = m_valid && m_ready;

  // A read is only issued when the word it returns is sure to have a slot:
  // occ + inflight - pop < 2, rearranged to avoid an underflowing subtract.
  // Gated by reset so no read is granted while the adapter is held in reset.
  assign fifo_rd_en = rd_reset_n && !fifo_empty && !flush &&
                      (level < (3'd2 + {2'b00, pop}));

  // State, in-flight flag and buffer slots.
  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      state    <= S_EMPTY;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      head     <= head_nxt;
      tail     <= tail_nxt;
    end
  end

  // Next occupancy state and slot contents: capture the in-flight word into
  // the tail position that remains after this cycle's pop.
  always_comb begin
    state_nxt    = state;
    inflight_nxt = fifo_rd_en;
    head_nxt     = head;
    tail_nxt     = tail;
    if (flush) begin
      state_nxt    = S_EMPTY;
      inflight_nxt = 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (inflight) begin
            head_nxt  = fifo_data;
            state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          case ({inflight, pop})
            2'b11: head_nxt = fifo_data;
            2'b10: begin
              tail_nxt  = fifo_data;
              state_nxt = S_TWO;
            end
            2'b01: state_nxt = S_EMPTY;
            default: ;
          endcase
        end
        S_TWO: begin
          // Full buffer never has a word in flight, so only a pop moves it;
          // the capture branch is kept so order is preserved regardless.
          if (pop) begin
            head_nxt = tail;
            if (inflight) begin
              tail_nxt = fifo_data;
            end else begin
              state_nxt = S_ONE;
            end
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_PERF_EN
  // Saturating counters of accepted words and backpressure cycles; flush
  // leaves them alone, only perf_clr or reset clears them.
  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      perf_words  <= 16'h0000;
      perf_stalls <= 16'h0000;
    end else if (perf_clr) begin
      perf_words  <= 16'h0000;
      perf_stalls <= 16'h0000;
    end else begin
      if (pop && (perf_words != 16'hFFFF)) begin
        perf_words <= perf_words + 16'd1;
      end
      if (m_valid && !m_ready && (perf_stalls != 16'hFFFF)) begin
        perf_stalls <= perf_stalls + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: behavioural FIFO read port, directed stimulus,
// and a scoreboard monitor that checks every accepted stream word in order.

module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          rd_clk = 1'b0;
  logic          rd_reset_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STREAM_PERF_EN
  logic          perf_clr = 1'b0;
  logic [15:0]   perf_words;
  logic [15:0]   perf_stalls;
`endif

  logic [DW-1:0] mem [0:1023];
  logic [9:0]    wr_ptr = '0;
  logic [9:0]    rd_ptr = '0;
  logic          fifo_clear = 1'b0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_w;
  int            checks = 0;
  int            failures = 0;
  int            level = 0;
  int            max_level = 0;
  logic [6:0]    exp_rd_tbl;
  logic [6:0]    exp_v_tbl;
  int            n;

  fifo_rd_stream #(.data_width(DW)) dut (
    .rd_clk     (rd_clk),
    .rd_reset_n (rd_reset_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_RD_STREAM_PERF_EN
    ,
    .perf_clr   (perf_clr),
    .perf_words (perf_words),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO read port model: data_out updates at the edge that grants a read.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge rd_clk) begin
    if (fifo_clear) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 10'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 10'd1;
    exp_q.push_back(w);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge rd_clk);
      k++;
    end
    step();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge rd_clk);
        if (!rd_reset_n) begin
          level = 0;
        end else begin
          if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sb_unexpected actual=%0h required=no_word", m_data);
            end else begin
              exp_w = exp_q.pop_front();
              chk("sb_data", 32'(m_data), 32'(exp_w));
            end
          end
          if (flush) level = 0;
          else level = level + int'(fifo_rd_en) - int'(m_valid && m_ready);
          if (level > max_level) max_level = level;
        end
      end
    join_none

    // Reset state
    #12;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    step();
    rd_reset_n = 1'b1;
    step();

    // Four preloaded words, m_ready high: reads on 4 cycles, valid from c2
    m_ready = 1'b1;
    load(8'd1); load(8'd2); load(8'd3); load(8'd4);
    exp_rd_tbl = 7'b0001111;
    exp_v_tbl  = 7'b0111100;
    for (int c = 0; c < 7; c++) begin
      @(negedge rd_clk);
      chk("stream_rd_en", 32'(fifo_rd_en), 32'(exp_rd_tbl[c]));
      chk("stream_valid", 32'(m_valid), 32'(exp_v_tbl[c]));
    end
    drain("stream_drain", 20);

    // Backpressure: two reads, then hold word 1 until accepted
    m_ready = 1'b0;
    load(8'd1); load(8'd2); load(8'd3); load(8'd4); load(8'd5);
    exp_rd_tbl = 7'b0000011;
    exp_v_tbl  = 7'b0111100;
    for (int c = 0; c < 6; c++) begin
      @(negedge rd_clk);
      chk("bp_rd_en", 32'(fifo_rd_en), 32'(exp_rd_tbl[c]));
      chk("bp_valid", 32'(m_valid), 32'(exp_v_tbl[c]));
      if (exp_v_tbl[c]) chk("bp_hold_data", 32'(m_data), 32'd1);
    end
    step();
    m_ready = 1'b1;
    drain("bp_drain", 40);

    // Pseudo-random backpressure over 200 words
    for (int i = 0; i < 200; i++) load(DW'((i * 37 + 11) & 8'hFF));
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1'b1;
    drain("rand_drain", 20);
    chk("occ_inflight_bound", 32'(max_level <= 2), 32'd1);

    // Flush with occ + inflight at 2 after word 1 was taken: next word is 4
    m_ready = 1'b0;
    load(8'd1); load(8'd2); load(8'd3); load(8'd4); load(8'd5); load(8'd6);
    repeat (4) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    flush = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    @(negedge rd_clk);
    chk("flush_rd_en", 32'(fifo_rd_en), 32'd0);
    step();
    flush = 1'b0;
    @(negedge rd_clk);
    chk("flush_valid", 32'(m_valid), 32'd0);
    step();
    m_ready = 1'b1;
    drain("flush_drain", 30);

    // Asynchronous reset mid-stream
    load(8'h50); load(8'h51); load(8'h52); load(8'h53);
    load(8'h54); load(8'h55); load(8'h56); load(8'h57);
    repeat (3) step();
    #2;
    rd_reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("arst_data", 32'(m_data), 32'd0);
    exp_q.delete();
    fifo_clear = 1'b1;
    @(posedge rd_clk);
    #1;
    fifo_clear = 1'b0;
    @(posedge rd_clk);
    #3;
    rd_reset_n = 1'b1;
    step();
    @(negedge rd_clk);
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    step();
    load(8'hC1); load(8'hC2); load(8'hC3);
    drain("post_rst_drain", 30);

`ifdef FIFO_RD_STREAM_PERF_EN
    // 10 accepted words, 3 stall cycles, then clear
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) load(DW'(8'h20 + i));
    repeat (5) step();
    m_ready = 1'b1;
    drain("perf_drain", 40);
    chk("perf_words", 32'(perf_words), 32'd10);
    chk("perf_stalls", 32'(perf_stalls), 32'd3);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("perf_clr_words", 32'(perf_words), 32'd0);
    chk("perf_clr_stalls", 32'(perf_stalls), 32'd0);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
